// File: rtl/mem_arbiter_if.sv
// Unified memory port bundle between mem_arbiter (master) and the memory model (slave).
// Signal names carry the arbiter's point of view: o_* are driven by the arbiter, i_* by memory.
interface mem_arbiter_if;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [31:0] o_mem_wmask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates CPU fetch and data ports onto one memory port, one transaction at a time.
// Optional fetch starvation guard: define MEM_ARBITER_FETCH_GUARD_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [31:0]         i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [31:0]         o_if_rdata,
  input  logic                i_d_req,
  input  logic [31:0]         i_d_addr,
  input  logic                i_d_we,
  input  logic [31:0]         i_d_wdata,
  input  logic [31:0]         i_d_wmask,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [31:0]         o_d_rdata,
  mem_arbiter_if.master       mem_if,
  output logic [1:0]          o_dbg_state
);

  // Handshake: a requester holds i_*_req until it sees o_*_gnt in the same cycle;
  // memory accepts when i_mem_gnt is high while o_mem_req is high, and answers with
  // a later single-cycle i_mem_rvalid. o_*_rvalid pulses one cycle after that.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_force_fetch;
  logic        r_owner_d;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_wmask;
  logic        r_if_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

`ifdef MEM_ARBITER_FETCH_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_fetch = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) && i_if_req;

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && i_if_req) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_fetch = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_rst) begin
          if (i_d_req && !w_force_fetch) begin
            w_d_gnt = 1'b1;
          end else if (i_if_req) begin
            w_if_gnt = 1'b1;
          end
        end
        if (w_d_gnt || w_if_gnt) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_if.i_mem_gnt) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_if.i_mem_rvalid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_d_gnt) begin
        r_owner_d <= 1'b1;
        r_addr    <= i_d_addr;
        r_we      <= i_d_we;
        r_wdata   <= i_d_wdata;
        r_wmask   <= i_d_wmask;
      end else if (w_if_gnt) begin
        r_owner_d <= 1'b0;
        r_addr    <= i_if_addr;
        r_we      <= 1'b0;
        r_wdata   <= '0;
        r_wmask   <= '0;
      end
      // Responses only count while a transaction is outstanding.
      if (r_state == ST_WAIT && mem_if.i_mem_rvalid) begin
        if (r_owner_d) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= mem_if.i_mem_rdata;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_if.i_mem_rdata;
        end
      end
    end
  end

  assign o_if_gnt           = w_if_gnt;
  assign o_d_gnt            = w_d_gnt;
  assign o_if_rvalid        = r_if_rvalid;
  assign o_d_rvalid         = r_d_rvalid;
  assign o_if_rdata         = r_if_rdata;
  assign o_d_rdata          = r_d_rdata;
  assign mem_if.o_mem_req   = (r_state == ST_ISSUE);
  assign mem_if.o_mem_addr  = r_addr;
  assign mem_if.o_mem_we    = r_we;
  assign mem_if.o_mem_wdata = r_wdata;
  assign mem_if.o_mem_wmask = r_wmask;
  assign o_dbg_state        = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch port and the CPU data port.
- Accepts one request at a time, drives the memory request/grant/response handshake, and routes the read data back to the requester that issued it.
- Sits between the cpu core and the unified memory model, replacing the separate instruction and data memories.
- Data port has fixed priority over fetch so a stalled MEM stage always drains.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_if_req  in  1  fetch request
- i_if_addr  in  32  fetch address
- o_if_gnt  out  1  fetch request accepted (comb)
- o_if_rvalid  out  1  fetch data valid, 1-cycle pulse
- o_if_rdata  out  32  fetch data
- i_d_req  in  1  data request
- i_d_addr  in  32  data address
- i_d_we  in  1  data write
- i_d_wdata  in  32  write data
- i_d_wmask  in  32  bit write mask
- o_d_gnt  out  1  data request accepted (comb)
- o_d_rvalid  out  1  data response pulse (reads and writes)
- o_d_rdata  out  32  data read data
- o_mem_req  out  1  memory request
- o_mem_addr  out  32  memory address
- o_mem_we  out  1  memory write
- o_mem_wdata  out  32  memory write data
- o_mem_wmask  out  32  memory write mask
- i_mem_gnt  in  1  memory accepted request
- i_mem_rvalid  in  1  memory response; read data or write ack
- i_mem_rdata  in  32  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is present, grant exactly one requester.
  - Data wins over fetch when both request.
  - The granted port's o_*_gnt is high that cycle. It is combinational from i_*_req and the state.
  - Latch addr/we/wdata/wmask (fetch: we=0, wdata=0, wmask=0) and the owner bit. Next state is ISSUE.
  - Requester may deassert or change its inputs after the grant.
- ISSUE:
  - o_mem_req=1 with latched fields, held stable until i_mem_gnt.
  - On i_mem_gnt, go to WAIT.
  - The fields must not change while stalled.
- WAIT:
  - o_mem_req=0.
  - On i_mem_rvalid, register i_mem_rdata into the owner's o_*_rdata, pulse the owner's o_*_rvalid on the next cycle, and go to IDLE.
  - The IDLE cycle that shows rvalid may grant a new request.
- Gating of memory inputs:
  - i_mem_rvalid outside WAIT is ignored.
  - i_mem_gnt outside ISSUE is ignored.
  - Memory must not return rvalid in the same cycle as gnt.
- Timing:
  - Minimum latency, with mem gnt in the first ISSUE cycle and rvalid one cycle later: request at cycle N, o_mem_req at N+1, o_*_rvalid at N+3.
  - Minimum throughput is one transaction per 3 cycles.
- Exclusivity:
  - o_if_gnt and o_d_gnt are never high together.
  - o_if_rvalid and o_d_rvalid are never high together.
- o_*_rdata hold their last value between pulses. The non-owner's rdata is unchanged.
- Writes complete through the same path: o_d_rvalid pulses on the write ack, and o_d_rdata is loaded with i_mem_rdata (don't-care value).
- Reset values: state=IDLE; o_mem_req=0; o_mem_addr, o_mem_wdata, o_mem_wmask, o_mem_we=0; o_if_rvalid=o_d_rvalid=0; o_if_rdata=o_d_rdata=0; o_*_gnt=0 while i_rst is high.
- Reset mid-transaction: the outstanding request is abandoned. A later i_mem_rvalid is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: MEM_ARBITER_FETCH_GUARD_EN.
- Enabled:
  - A 3-bit-wide-enough counter increments on each data grant made while i_if_req is high.
  - The counter clears on any fetch grant and on reset.
  - When the counter equals STARVE_LIMIT and both ports request in IDLE, fetch wins, and the counter then clears.
- Disabled: strict data priority, no counter logic.

Test Plan:
- Single fetch: i_if_req=1, addr=0x10; memory gnts immediately, rvalid next cycle with 0x00000013 -> o_if_gnt at cycle 0, o_mem_req at cycle 1 with addr 0x10 and we=0, o_if_rvalid pulse at cycle 3, o_if_rdata=0x00000013.
- Collision: both request in the same IDLE cycle, d_addr=0x8, read -> o_d_gnt=1, o_if_gnt=0; data completes with its rdata; fetch is granted in the IDLE cycle where o_d_rvalid is high.
- Write with memory backpressure: d_we=1, addr=0x8, wdata=0xcafeb0ba, wmask=0xffffffff; i_mem_gnt held low 3 cycles -> o_mem_req and all fields stable for 4 cycles; o_d_rvalid pulses one cycle after the ack.
- Reset mid-operation: assert i_rst in WAIT, then i_mem_rvalid=1 the next cycle -> no o_*_rvalid, state IDLE, all outputs at reset values.
- Spurious response: i_mem_rvalid=1 in IDLE with rdata 0xdeadbeef -> no rvalid pulse, rdata registers unchanged.
- Guard on (MEM_ARBITER_FETCH_GUARD_EN, STARVE_LIMIT=4): both ports request continuously -> grant sequence D,D,D,D,F,D,D,D,D,F; guard off -> all D.
